// File: rtl/sum4_bist_checker.sv
// ============================================================================
// Module   : sum4_bist_checker
// Function : On-board self-test for a four-operand 2-bit adder. Sweeps every
//            operand vector, checks the adder result against a delayed expected
//            sum, counts mismatches and latches the first failing vector index.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sum4_bist_checker #(
  parameter int LATENCY = 2,    // operand-to-result delay of the adder, 1..8
  parameter int NUM_VEC = 256   // vectors per run, 1..256
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Start,
  input  logic       Abort,
  input  logic [4:0] Out_i,
  output logic [1:0] A_o,
  output logic [1:0] B_o,
  output logic [1:0] C_o,
  output logic [1:0] D_o,
  output logic       Busy,
  output logic       Done,
  output logic       Pass,
  output logic [8:0] Err_cnt,
  output logic [7:0] Fail_idx,
  output logic       Fail_vld
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] C_LAST_IDX   = 8'(NUM_VEC - 1);
  localparam logic [3:0] C_LAST_DRAIN = 4'(LATENCY - 1);
  localparam logic [8:0] C_ERR_MAX    = 9'h1FF;

  state_t             state_q, state_d;
  logic [7:0]         idx_q, idx_d;
  logic [7:0]         ops_q, ops_d;
  logic [3:0]         drain_q, drain_d;
  logic [4:0]         pexp_q [LATENCY];
  logic [4:0]         pexp_d [LATENCY];
  logic [7:0]         pidx_q [LATENCY];
  logic [7:0]         pidx_d [LATENCY];
  logic [LATENCY-1:0] pvld_q, pvld_d;
  logic [8:0]         err_q, err_d;
  logic [7:0]         fidx_q, fidx_d;
  logic               fvld_q, fvld_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [4:0]         w_exp;
  logic               w_mismatch;

  assign w_exp = 5'(ops_q[1:0]) + 5'(ops_q[3:2]) + 5'(ops_q[5:4]) + 5'(ops_q[7:6]);
  assign w_mismatch = pvld_q[LATENCY-1] && (Out_i != pexp_q[LATENCY-1]);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ops_d   = ops_q;
    drain_d = drain_q;
    err_d   = err_q;
    fidx_d  = fidx_q;
    fvld_d  = fvld_q;
    done_d  = done_q;
    pass_d  = pass_q;

    // Expected sum travels alongside the adder so both arrive at the compare together.
    pexp_d    = pexp_q;
    pidx_d    = pidx_q;
    pexp_d[0] = w_exp;
    pidx_d[0] = idx_q;
    pvld_d[0] = (state_q == S_RUN);
    for (int i = 1; i < LATENCY; i++) begin
      pexp_d[i] = pexp_q[i-1];
      pidx_d[i] = pidx_q[i-1];
      pvld_d[i] = pvld_q[i-1];
    end

    if (w_mismatch) begin
      if (err_q != C_ERR_MAX) err_d = err_q + 9'd1;
      if (!fvld_q) begin
        fidx_d = pidx_q[LATENCY-1];
        fvld_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          state_d = S_RUN;
          idx_d   = '0;
          ops_d   = '0;
          err_d   = '0;
          fidx_d  = '0;
          fvld_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          pvld_d  = '0;
        end
      end
      S_RUN: begin
        if (Abort) begin
          state_d = S_IDLE;
          ops_d   = '0;
          pvld_d  = '0;
        end else if (idx_q == C_LAST_IDX) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          idx_d = idx_q + 8'd1;
          ops_d = idx_q + 8'd1;
        end
      end
      S_DRAIN: begin
        if (Abort) begin
          state_d = S_IDLE;
          ops_d   = '0;
          pvld_d  = '0;
        end else if (drain_q == C_LAST_DRAIN) begin
          // The final compare lands on this same edge, so judge on the updated count.
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          drain_d = drain_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      ops_q   <= '0;
      drain_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pexp_q[i] <= '0;
        pidx_q[i] <= '0;
      end
      pvld_q  <= '0;
      err_q   <= '0;
      fidx_q  <= '0;
      fvld_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ops_q   <= ops_d;
      drain_q <= drain_d;
      pexp_q  <= pexp_d;
      pidx_q  <= pidx_d;
      pvld_q  <= pvld_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      fvld_q  <= fvld_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign A_o      = ops_q[1:0];
  assign B_o      = ops_q[3:2];
  assign C_o      = ops_q[5:4];
  assign D_o      = ops_q[7:6];
  assign Busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign Done     = done_q;
  assign Pass     = pass_q;
  assign Err_cnt  = err_q;
  assign Fail_idx = fidx_q;
  assign Fail_vld = fvld_q;

endmodule

`default_nettype wire

// File: tb/tb_sum4_bist_checker.sv
// ============================================================================
// Module   : tb_sum4_bist_checker
// Function : Self-checking bench; a behavioural adder with selectable delay and
//            stuck-at faults feeds the checker, results checked against a model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sum4_bist_checker;

  localparam int LAT = 2;
  localparam int NV  = 256;

  logic       clk = 1'b0;
  logic       rst_n, start, abort;
  logic [4:0] out_i;
  logic [1:0] a_o, b_o, c_o, d_o;
  logic       busy, done, pass, fail_vld;
  logic [8:0] err_cnt;
  logic [7:0] fail_idx;
  logic [7:0] ops;

  int n_checks = 0;
  int n_fail   = 0;
  int prev_sum = 0;

  // Behavioural adder under test: up to 3 register stages plus fault masks.
  int         m_delay = 2;
  logic [4:0] m_and   = 5'h1F;
  logic [4:0] m_or    = 5'h00;
  logic [4:0] m1 = '0, m2 = '0, m3 = '0;
  logic [4:0] m_raw;

  sum4_bist_checker #(.LATENCY(LAT), .NUM_VEC(NV)) dut (
    .Clk(clk), .Rst_n(rst_n), .Start(start), .Abort(abort), .Out_i(out_i),
    .A_o(a_o), .B_o(b_o), .C_o(c_o), .D_o(d_o),
    .Busy(busy), .Done(done), .Pass(pass), .Err_cnt(err_cnt),
    .Fail_idx(fail_idx), .Fail_vld(fail_vld)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    m1 <= 5'(a_o) + 5'(b_o) + 5'(c_o) + 5'(d_o);
    m2 <= m1;
    m3 <= m2;
  end
  assign m_raw = (m_delay == 1) ? m1 : (m_delay == 2) ? m2 : m3;
  assign out_i = (m_raw & m_and) | m_or;
  assign ops   = {d_o, c_o, b_o, a_o};

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int vecsum(input int v);
    return (v % 4) + ((v / 4) % 4) + ((v / 16) % 4) + ((v / 64) % 4);
  endfunction

  // Vector k is judged against whatever the adder shows LAT cycles after it was
  // first driven; with a delay d that is the sum of vector k+LAT-d (held operands
  // before the run and after its last vector).
  function automatic int exp_errs(input int d, input int am, input int om,
                                  input int prev, input int kmax, output int first);
    int errs, j, src, obs;
    errs  = 0;
    first = -1;
    for (int k = 0; k <= kmax && k < NV; k++) begin
      j   = k + LAT - d;
      src = (j < 0) ? prev : (j > NV - 1) ? vecsum(NV - 1) : vecsum(j);
      obs = (src & am) | om;
      if (obs != vecsum(k)) begin
        errs++;
        if (first < 0) first = k;
      end
    end
    return (errs > 511) ? 511 : errs;
  endfunction

  task automatic wait_vec(input int v, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 600; t++) begin
      if (int'(ops) == v) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic set_model(input int d, input int am, input int om);
    m_delay = d;
    m_and   = 5'(am);
    m_or    = 5'(om);
    repeat (4) @(negedge clk);
  endtask

  task automatic run_full(input string tag, input int d, input int am, input int om);
    int n, op_err, e_err, e_first, exp_v;
    bit fin;
    set_model(d, am, om);
    pulse_start();
    n = 0; op_err = 0; fin = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      if (done) begin
        fin = 1'b1;
        break;
      end
      if (busy) n++;
      exp_v = (t < NV) ? t : NV - 1;
      if (int'(ops) != exp_v) op_err++;
      @(negedge clk);
    end
    e_err = exp_errs(d, am, om, prev_sum, NV - 1, e_first);
    check({tag, ".done"},     int'(fin),      1);
    check({tag, ".busy_cyc"}, n,              NV + LAT);
    check({tag, ".ops_seq"},  op_err,         0);
    check({tag, ".busy_end"}, int'(busy),     0);
    check({tag, ".err_cnt"},  int'(err_cnt),  e_err);
    check({tag, ".pass"},     int'(pass),     (e_err == 0) ? 1 : 0);
    check({tag, ".fail_vld"}, int'(fail_vld), (e_err > 0) ? 1 : 0);
    check({tag, ".fail_idx"}, int'(fail_idx), (e_err > 0) ? e_first : 0);
    prev_sum = vecsum(NV - 1);
  endtask

  task automatic run_abort(input string tag, input int d, input int am, input int om, input int j);
    int lo, hi, f_lo, f_hi;
    bit ok;
    set_model(d, am, om);
    pulse_start();
    wait_vec(j, ok);
    check({tag, ".reach"}, int'(ok), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    lo = exp_errs(d, am, om, prev_sum, j - 1 - LAT, f_lo);
    hi = exp_errs(d, am, om, prev_sum, j - LAT, f_hi);
    check({tag, ".busy"},   int'(busy), 0);
    check({tag, ".done"},   int'(done), 0);
    check({tag, ".ops"},    int'(ops),  0);
    check({tag, ".err_in_range"}, int'(int'(err_cnt) >= lo && int'(err_cnt) <= hi), 1);
    if (lo > 0) check({tag, ".fail_idx"}, int'(fail_idx), f_lo);
    if (lo > 0) check({tag, ".fail_vld"}, int'(fail_vld), 1);
    if (hi == 0) check({tag, ".fail_vld0"}, int'(fail_vld), 0);
    repeat (3) @(negedge clk);
    check({tag, ".idle_busy"}, int'(busy), 0);
    prev_sum = 0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int d, kind, b, am, om;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.busy",     int'(busy),     0);
    check("rst.done",     int'(done),     0);
    check("rst.pass",     int'(pass),     0);
    check("rst.err_cnt",  int'(err_cnt),  0);
    check("rst.fail_idx", int'(fail_idx), 0);
    check("rst.fail_vld", int'(fail_vld), 0);
    check("rst.ops",      int'(ops),      0);
    rst_n = 1'b1;
    @(negedge clk);

    run_full("ideal",     2, 5'h1F, 5'h00);
    run_full("out0_sa0",  2, 5'h1E, 5'h00);
    check("out0_sa0.err128", int'(err_cnt), 128);
    run_full("out4_sa1",  2, 5'h1F, 5'h10);
    check("out4_sa1.err256", int'(err_cnt), 256);
    run_full("clean",     2, 5'h1F, 5'h00);
    run_full("lat3",      3, 5'h1F, 5'h00);
    check("lat3.nonzero", int'(err_cnt != 0), 1);

    // Extra Start mid-run is ignored, Abort returns to IDLE.
    set_model(2, 5'h1F, 5'h00);
    pulse_start();
    wait_vec(10, ok);
    check("s5.reach10", int'(ok), 1);
    pulse_start();
    check("s5.ops_after_start", int'(ops),  11);
    check("s5.busy_after_start", int'(busy), 1);
    wait_vec(50, ok);
    check("s5.reach50", int'(ok), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("s5.busy", int'(busy), 0);
    check("s5.done", int'(done), 0);
    check("s5.ops",  int'(ops),  0);
    check("s5.err",  int'(err_cnt), 0);
    prev_sum = 0;

    // Start and Abort together: Start wins in IDLE, Abort wins in RUN.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("both.idle_start", int'(busy), 1);
    wait_vec(20, ok);
    check("both.reach20", int'(ok), 1);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("both.run_abort", int'(busy), 0);
    check("both.ops",       int'(ops),  0);

    // Asynchronous reset mid-run.
    repeat (4) @(negedge clk);
    pulse_start();
    wait_vec(100, ok);
    check("s6.reach100", int'(ok), 1);
    rst_n = 1'b0;
    #1;
    check("s6.busy",    int'(busy),     0);
    check("s6.ops",     int'(ops),      0);
    check("s6.err",     int'(err_cnt),  0);
    check("s6.fvld",    int'(fail_vld), 0);
    check("s6.fidx",    int'(fail_idx), 0);
    check("s6.done",    int'(done),     0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("s6.stay_idle", int'(busy), 0);
    prev_sum = 0;
    run_full("s6.rerun", 2, 5'h1F, 5'h00);

    for (int it = 0; it < 6; it++) begin
      d    = $urandom_range(1, 3);
      kind = $urandom_range(0, 2);
      b    = $urandom_range(0, 4);
      am   = (kind == 1) ? (5'h1F & ~(1 << b)) : 5'h1F;
      om   = (kind == 2) ? (1 << b) : 0;
      run_full($sformatf("rnd%0d", it), d, am, om);
    end

    for (int it = 0; it < 3; it++) begin
      d    = $urandom_range(1, 3);
      b    = $urandom_range(0, 4);
      am   = 5'h1F & ~(1 << b);
      run_abort($sformatf("rab%0d", it), d, am, 0, $urandom_range(LAT + 1, 200));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
